// File: rtl/comparator_seq_ctrl.sv
// comparator_seq_ctrl: streams two operands MSB-first through an external 1-bit comparator and latches the first decisive result
module comparator_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             LED1,
  output logic             LED2,
  output logic             LED3
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, COMPARE, FINISH} state_t;
  state_t state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0] idx;
  logic [2:0] code;
  logic decided;
  assign code = {cmp_gt, cmp_eq, cmp_lt};
  assign cmp_a = a_reg[idx];
  assign cmp_b = b_reg[idx];
  // an equal pair only ends the scan once the LSB has been compared
  assign decided = code == 3'b100 || code == 3'b001 || (code == 3'b010 && idx == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      {LED1, LED2, LED3} <= 3'b000;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= A_in;
          b_reg <= B_in;
          idx <= IW'(WIDTH - 1);
          busy <= 1'b1;
          state <= COMPARE;
        end
        COMPARE: if (decided) begin
          {LED1, LED2, LED3} <= code;
          done <= 1'b1;
          state <= FINISH;
        end else if (code == 3'b010) begin
          idx <= idx - 1'b1;
        end else begin
          {LED1, LED2, LED3} <= 3'b000;
          err <= 1'b1;
          done <= 1'b1;
          state <= FINISH;
        end
        FINISH: begin
          done <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// tb_comparator_seq_ctrl: randomized check of the sequencing controller against a first-differing-bit reference model
module tb_comparator_seq_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] A_in = '0, B_in = '0;
  logic cmp_a, cmp_b, cmp_gt, cmp_eq, cmp_lt;
  logic busy, done, err, LED1, LED2, LED3;
  logic fault = 1'b0;
  logic [2:0] fault_code = 3'b000;
  int total = 0, bad = 0;
  comparator_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A_in(A_in), .B_in(B_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .err(err), .LED1(LED1), .LED2(LED2), .LED3(LED3)
  );
  assign {cmp_gt, cmp_eq, cmp_lt} = fault ? fault_code : {cmp_a & ~cmp_b, ~(cmp_a ^ cmp_b), ~cmp_a & cmp_b};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble, input bit inject, input logic [2:0] fcode);
    int lat, n;
    logic [2:0] leds_prev, leds_exp;
    bit seen;
    lat = W;
    for (int i = 0; i < W; i++) if (a[i] != b[i]) lat = W - i;
    leds_exp = a > b ? 3'b100 : (a < b ? 3'b001 : 3'b010);
    if (inject) begin
      lat = 1;
      leds_exp = 3'b000;
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    leds_prev = {LED1, LED2, LED3};
    A_in = a;
    B_in = b;
    start = 1'b1;
    fault = inject;
    fault_code = fcode;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n <= 4 * W + 10) begin
      if (done) begin
        seen = 1;
        check("latency", n, lat);
        check("leds", {LED1, LED2, LED3}, leds_exp);
        check("err", err, inject);
        check("busy_done", busy, 1);
      end else begin
        check("busy", busy, 1);
        check("leds_hold", {LED1, LED2, LED3}, leds_prev);
        if (!inject && n < W) begin
          check("cmp_a", cmp_a, a[W-1-n]);
          check("cmp_b", cmp_b, b[W-1-n]);
        end
        if (scramble) begin
          A_in = W'($urandom);
          B_in = W'($urandom);
          start = 1'($urandom);
        end
        @(negedge clk);
        n++;
      end
    end
    if (!seen) check("timeout", n, lat);
    start = 1'b0;
    fault = 1'b0;
    @(negedge clk);
    check("done_clr", done, 0);
    check("err_clr", err, 0);
    check("busy_fall", busy, 0);
    check("leds_keep", {LED1, LED2, LED3}, leds_exp);
    @(negedge clk);
    check("no_restart", busy, 0);
  endtask
  initial begin
    logic [W-1:0] a, b;
    int gap;
    bit seen;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_leds", {LED1, LED2, LED3}, 0);
    check("rst_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_cmp(8'h80, 8'h7F, 0, 0, 3'b000);
    run_cmp(8'h12, 8'h13, 0, 0, 3'b000);
    run_cmp(8'hA5, 8'hA5, 0, 0, 3'b000);
    run_cmp(8'h3C, 8'h3C, 0, 1, 3'b000);
    run_cmp(8'h01, 8'hF0, 0, 1, 3'b111);
    run_cmp(8'h4D, 8'h4B, 1, 0, 3'b000);
    @(negedge clk);
    A_in = 8'hA5;
    B_in = 8'hA5;
    start = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("b2b_first", seen, 1);
    gap = 0;
    seen = 0;
    while (!seen && gap < 40) begin
      @(negedge clk);
      gap++;
      seen = done;
    end
    check("b2b_gap", gap, 10);
    check("b2b_leds", {LED1, LED2, LED3}, 3'b010);
    start = 1'b0;
    repeat (3) @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      a = W'($urandom);
      b = $urandom_range(0, 2) == 0 ? a : (a ^ (W'(1) << $urandom_range(0, W - 1)));
      if ($urandom_range(0, 3) == 0) b = W'($urandom);
      run_cmp(a, b, 1'($urandom), $urandom_range(0, 7) == 0, 3'b101);
    end
    run_cmp(8'h00, 8'h01, 0, 0, 3'b000);
    @(negedge clk);
    A_in = 8'h80;
    B_in = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_leds", {LED1, LED2, LED3}, 0);
    check("arst_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check("arst_quiet", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
